// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants, state encodings and entry type for the
//               instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    // exception_out is EX_WIDTH+1 bits wide
    localparam int EX_WIDTH = 3;

    localparam logic [EX_WIDTH:0] EX_INSTR_MISALIGNED   = 4'd0;
    localparam logic [EX_WIDTH:0] EX_INSTR_ACCESS_FAULT = 4'd1;
    localparam logic [EX_WIDTH:0] EX_ILLEGAL_INSTR      = 4'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] S_REQ  = 3'd1;
    localparam logic [STATE_W-1:0] S_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] S_HOLD = 3'd3;
    localparam logic [STATE_W-1:0] S_HALT = 3'd4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [EX_WIDTH:0] exc;
        logic              exc_valid;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(
        input logic [31:0]       pc,
        input logic [31:0]       instr,
        input logic [EX_WIDTH:0] exc,
        input logic              exc_valid
    );
        fetch_entry_t e;
        e.pc        = pc;
        e.instr     = instr;
        e.exc       = exc;
        e.exc_valid = exc_valid;
        return e;
    endfunction

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Instruction memory request/response bundle between the fetch
//               stage (master) and instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_error;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  imem_resp_error
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output imem_resp_error
    );

endinterface
`default_nettype wire

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module      : fetch
// Description : Instruction fetch stage - owns the PC, keeps one request in
//               flight and presents {PC, instr, exception, valid} to decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,

    fetch_if.master           imem,

    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    input  logic              stall,
    input  logic              flush,

    output logic [31:0]       PC_out,
    output logic [31:0]       instr_out,
    output logic [EX_WIDTH:0] exception_out,
    output logic              exception_out_valid,
    output logic              pipeline_out_valid
);

    logic [STATE_W-1:0] r_state;
    logic [31:0]        r_pc;
    logic               r_drop;
    logic               r_hold_valid;
    fetch_entry_t       r_hold;

    logic               w_misaligned;
    logic               w_req_fire;
    fetch_entry_t       w_entry;
    logic               w_entry_valid;
    logic               w_from_hold;
    logic               w_accept;
    logic               w_deliver;
    logic               w_park;
    logic [STATE_W-1:0] w_after;
    logic [STATE_W-1:0] w_state_next;
    logic               w_drop_next;

    // A misaligned PC never reaches memory; it turns into an exception entry.
    assign w_misaligned        = (r_pc[1:0] != 2'b00);
    assign imem.imem_req_valid = (r_state == S_REQ) && !w_misaligned;
    assign imem.imem_req_addr  = r_pc;
    assign w_req_fire          = imem.imem_req_valid && imem.imem_req_ready;

    always_comb begin
        w_entry       = make_entry(r_pc, NOP_INSTR, '0, 1'b0);
        w_entry_valid = 1'b0;
        w_from_hold   = 1'b0;
        case (r_state)
            S_REQ: begin
                if (w_misaligned) begin
                    w_entry_valid     = 1'b1;
                    w_entry.exc       = EX_INSTR_MISALIGNED;
                    w_entry.exc_valid = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem.imem_resp_valid && !r_drop) begin
                    w_entry_valid = 1'b1;
                    if (imem.imem_resp_error) begin
                        w_entry.exc       = EX_INSTR_ACCESS_FAULT;
                        w_entry.exc_valid = 1'b1;
                    end else begin
                        w_entry.instr = imem.imem_resp_data;
                    end
                end
            end
            S_HOLD: begin
                w_entry       = r_hold;
                w_entry_valid = r_hold_valid;
                w_from_hold   = 1'b1;
            end
            default: ;
        endcase
    end

    // Redirect and flush both kill whatever entry was built this cycle.
    assign w_accept  = w_entry_valid && !redirect_valid && !flush;
    assign w_deliver = w_accept && !stall;
    assign w_park    = w_accept && stall && !w_from_hold;
    assign w_after   = w_entry.exc_valid ? S_HALT : S_REQ;

    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        if (redirect_valid) begin
            // A request already accepted will still answer; swallow that answer.
            if (((r_state == S_WAIT) && !imem.imem_resp_valid) || w_req_fire) begin
                w_drop_next  = 1'b1;
                w_state_next = S_WAIT;
            end else begin
                w_drop_next  = 1'b0;
                w_state_next = S_REQ;
            end
        end else begin
            case (r_state)
                S_IDLE: w_state_next = S_REQ;
                S_REQ: begin
                    if (w_deliver) begin
                        w_state_next = w_after;
                    end else if (w_park) begin
                        w_state_next = S_HOLD;
                    end else if (w_req_fire) begin
                        w_state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_resp_valid) begin
                        w_drop_next = 1'b0;
                        if (w_deliver) begin
                            w_state_next = w_after;
                        end else if (w_park) begin
                            w_state_next = S_HOLD;
                        end else begin
                            w_state_next = S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (flush || !r_hold_valid) begin
                        w_state_next = S_REQ;
                    end else if (w_deliver) begin
                        w_state_next = w_after;
                    end
                end
                S_HALT:  w_state_next = S_HALT;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state             <= S_IDLE;
            r_pc                <= RESET_VECTOR;
            r_drop              <= 1'b0;
            r_hold_valid        <= 1'b0;
            r_hold              <= '0;
            PC_out              <= 32'h0000_0000;
            instr_out           <= NOP_INSTR;
            exception_out       <= '0;
            exception_out_valid <= 1'b0;
            pipeline_out_valid  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;

            // PC only advances once its entry has actually reached decode.
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_deliver) begin
                r_pc <= seq_pc(r_pc);
            end

            if (redirect_valid || flush) begin
                r_hold_valid <= 1'b0;
            end else if (w_park) begin
                r_hold_valid <= 1'b1;
                r_hold       <= w_entry;
            end else if (w_deliver && w_from_hold) begin
                r_hold_valid <= 1'b0;
            end

            if (flush) begin
                pipeline_out_valid  <= 1'b0;
                exception_out_valid <= 1'b0;
            end else if (!stall) begin
                if (w_deliver) begin
                    PC_out              <= w_entry.pc;
                    instr_out           <= w_entry.instr;
                    exception_out       <= w_entry.exc;
                    exception_out_valid <= w_entry.exc_valid;
                    pipeline_out_valid  <= 1'b1;
                end else begin
                    pipeline_out_valid  <= 1'b0;
                    exception_out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire
